// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
package down_timer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : down_timer_pkg

// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer: the master drives the commands,
// the timer (slave) returns count and status flags.
interface down_timer_if
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             mode_periodic;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, start, stop, mode_periodic,
    input  count, tc, busy, done
  );

  modport slave (
    input  load, load_val, start, stop, mode_periodic,
    output count, tc, busy, done
  );

endinterface : down_timer_if

// File: rtl/down_timer.sv
// Loadable, pausable down-counting timer with one-shot and periodic-reload
// modes. Terminal count (tc) is registered; busy/done decode the state.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  down_timer_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // One RUN-cycle step computed from the current count; shared by RUN and
  // by the resume edge out of PAUSE.
  logic [WIDTH-1:0] step_count;
  logic             step_tc;
  logic             step_done;
  logic [WIDTH-1:0] eff_val;

  // Decrement / zero-crossing / reload step for one running cycle.
  always_comb begin
    step_count = count_q;
    step_tc    = 1'b0;
    step_done  = 1'b0;
    if (count_q > ONE) begin
      step_count = count_q - ONE;
    end else if (count_q == ONE) begin
      step_count = '0;
      step_tc    = 1'b1;
      step_done  = ~bus.mode_periodic;
    end else begin
      // Zero already reached: the mode was decided at the crossing, so reload.
      step_count = reload_q;
      step_tc    = (reload_q == '0);
    end
  end

  // Next-state and datapath decode; priority stop > load > start.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    eff_val  = bus.load ? bus.load_val : count_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.stop) begin
          // stop has no effect here, but still masks load and start
        end else if (bus.start) begin
          if (bus.load) reload_d = bus.load_val;
          count_d = eff_val;
          if (eff_val != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            tc_d    = 1'b1;
          end
        end else if (bus.load) begin
          reload_d = bus.load_val;
          count_d  = bus.load_val;
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = PAUSE;
          tc_d    = tc_q;
        end else begin
          if (bus.load) reload_d = bus.load_val;
          count_d = step_count;
          tc_d    = step_tc;
          state_d = step_done ? DONE : RUN;
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          if (bus.load) reload_d = bus.load_val;
          if (bus.start) begin
            count_d = step_count;
            tc_d    = step_tc;
            state_d = step_done ? DONE : RUN;
          end else begin
            tc_d = tc_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, count, reload and tc registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = (state_q == RUN) || (state_q == PAUSE);
  assign bus.done  = (state_q == DONE);

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Directed vector bench for down_timer (WIDTH=8).
module tb_down_timer;

  localparam int W = 8;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         st;
    logic         sp;
    logic         mp;
    logic [W-1:0] ec;
    logic         etc;
    logic         eb;
    logic         ed;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  down_timer_if #(.WIDTH(W)) bus ();

  down_timer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [W-1:0] ec,
                            input logic etc, input logic eb, input logic ed);
    check({tag, ".count"}, idx, 32'(bus.count), 32'(ec));
    check({tag, ".tc"},    idx, 32'(bus.tc),    32'(etc));
    check({tag, ".busy"},  idx, 32'(bus.busy),  32'(eb));
    check({tag, ".done"},  idx, 32'(bus.done),  32'(ed));
  endtask

  task automatic drive(input logic ld, input logic [W-1:0] lv, input logic st,
                       input logic sp, input logic mp);
    bus.load          = ld;
    bus.load_val      = lv;
    bus.start         = st;
    bus.stop          = sp;
    bus.mode_periodic = mp;
  endtask

  vec_t vecs[$];

  function automatic vec_t v(input logic ld, input int lv, input logic st, input logic sp,
                             input logic mp, input int ec, input logic etc,
                             input logic eb, input logic ed);
    vec_t r;
    r.ld = ld; r.lv = W'(lv); r.st = st; r.sp = sp; r.mp = mp;
    r.ec = W'(ec); r.etc = etc; r.eb = eb; r.ed = ed;
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // One-shot 5 down to 0, then load while DONE returns to IDLE
    vecs.push_back(v(1, 5, 1, 0, 0, 5, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 3, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 2, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 2, 0, 0, 0, 2, 0, 0, 0));
    // Periodic reload 3, then reload changed to 1 mid-run
    vecs.push_back(v(1, 3, 1, 0, 1, 3, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 2, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 3, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 0, 1, 2, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // Pause at 6, hold, resume, then stop twice to abort
    vecs.push_back(v(1, 8, 1, 0, 0, 8, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 7, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 6, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 6, 0, 1, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0, 0, 0, 0, 0, 6, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 5, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 4, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 4, 0, 0, 0));
    // Zero load goes straight to DONE; periodic with reload 0 holds tc
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, 2, 1, 0, 1, 2, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // Conflicts: start+stop in IDLE, load+start, start while running
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 9, 1, 0, 0, 9, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 8, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 7, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 7, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 7, 0, 0, 0));
    // Plain load in IDLE, then start from the loaded count
    vecs.push_back(v(1, 4, 0, 0, 0, 4, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 4, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 3, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 3, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 3, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].mp);
      @(posedge clk);
      #1;
      check_outs("vec", i, vecs[i].ec, vecs[i].etc, vecs[i].eb, vecs[i].ed);
    end

    // Asynchronous reset in the middle of a run, between clock edges
    drive(1'b1, W'(10), 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("rst_run", 0, W'(10), 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst_run", 1, W'(8), 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_outs("rst_async", 0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_outs("rst_after", 0, '0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_down_timer
